// File: rtl/radiant_trig_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// radiant_trig_arbiter_pkg
// Shared constants and the saturating lost-counter helper.
// Revision: 1.0
// ============================================================================
package radiant_trig_arbiter_pkg;
  `include "radiant_trig_arb.vh"

  function automatic logic [c_LOST_W-1:0] lost_sat_add(
    input logic [c_LOST_W-1:0] cnt,
    input int unsigned         inc
  );
    int unsigned sum;
    sum = 32'(cnt) + inc;
    if (sum > c_LOST_MAX) return c_LOST_W'(c_LOST_MAX);
    return c_LOST_W'(sum);
  endfunction
endpackage
`default_nettype wire

// File: rtl/radiant_rr_arbiter.sv
`default_nettype none
// ============================================================================
// radiant_rr_arbiter
// Combinational round-robin picker: first set bit above pointer, wrapping.
// Revision: 1.0
// ============================================================================
module radiant_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   pointer,
  output logic [SRC_W-1:0]   grant,
  output logic               valid
);

  int w_idx;

  // Scan from farthest to nearest so the nearest candidate is written last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = 0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      w_idx = (int'(pointer) + i) % NUM_SRC;
      if (req[w_idx]) begin
        grant = SRC_W'(w_idx);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/radiant_trig_arb.vh
`default_nettype none
// ============================================================================
// radiant_trig_arb.vh
// FSM state encodings and lost-counter width for the trigger arbiter.
// Revision: 1.0
// ============================================================================
`ifndef RADIANT_TRIG_ARB_VH
`define RADIANT_TRIG_ARB_VH
localparam logic [2:0] c_ST_IDLE      = 3'd0;
localparam logic [2:0] c_ST_ISSUE     = 3'd1;
localparam logic [2:0] c_ST_WAIT_ACK  = 3'd2;
localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
localparam logic [2:0] c_ST_HOLDOFF   = 3'd4;

localparam int          c_LOST_W   = 16;
localparam int unsigned c_LOST_MAX = (32'd1 << c_LOST_W) - 32'd1;
`endif
`default_nettype wire

// File: rtl/radiant_trig_arbiter.sv
`default_nettype none
// ============================================================================
// radiant_trig_arbiter
// Prescaled, round-robin trigger sequencer with readout handshake and holdoff.
// Revision: 1.0
// ============================================================================
module radiant_trig_arbiter
  import radiant_trig_arbiter_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int PRESCALE_WIDTH = 8,
  parameter int HOLDOFF_WIDTH  = 16,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int SRC_W          = $clog2(NUM_SRC)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_SRC-1:0]                req_i,
  input  logic [NUM_SRC-1:0]                src_en_i,
  input  logic [NUM_SRC*PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [HOLDOFF_WIDTH-1:0]          holdoff_i,
  input  logic                              busy_i,
  input  logic                              trig_ack_i,
  input  logic                              done_i,
  input  logic                              lost_clr_i,
  output logic                              trig_o,
  output logic [SRC_W-1:0]                  trig_src_o,
  output logic [NUM_SRC-1:0]                trig_mask_o,
  output logic                              timeout_o,
  output logic [c_LOST_W-1:0]               lost_cnt_o,
  output logic [2:0]                        state_o
);

  localparam int c_TCNT_W = $clog2(ACK_TIMEOUT);

  logic [2:0]               r_state;
  logic [NUM_SRC-1:0]       r_pending;
  logic [SRC_W-1:0]         r_ptr;
  logic [SRC_W-1:0]         r_src;
  logic [NUM_SRC-1:0]       r_mask;
  logic                     r_timeout;
  logic [HOLDOFF_WIDTH-1:0] r_hcnt;
  logic [c_TCNT_W-1:0]      r_tcnt;
  logic [c_LOST_W-1:0]      r_lost;

  logic                     w_idle;
  logic [NUM_SRC-1:0]       w_pass;
  logic [SRC_W-1:0]         w_grant;
  logic                     w_valid;
  logic                     w_fire;
  logic [NUM_SRC-1:0]       w_lossv;
  logic [NUM_SRC-1:0]       w_pending_nxt;
  int unsigned              w_loss_n;

  assign w_idle = (r_state == c_ST_IDLE);
  assign w_fire = w_idle & w_valid & ~busy_i;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [PRESCALE_WIDTH-1:0] r_pcnt;
      logic                      w_elig;

      assign w_elig    = req_i[k] & src_en_i[k] & w_idle;
      assign w_pass[k] = w_elig &&
                         (r_pcnt == prescale_i[k*PRESCALE_WIDTH +: PRESCALE_WIDTH]);

      always_ff @(posedge clk_i) begin
        if (!rst_n_i)          r_pcnt <= '0;
        else if (!src_en_i[k]) r_pcnt <= '0;
        else if (w_elig)       r_pcnt <= w_pass[k] ? '0 : r_pcnt + 1'b1;
      end
    end
  endgenerate

  radiant_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr (
    .req     (r_pending),
    .pointer (r_ptr),
    .grant   (w_grant),
    .valid   (w_valid)
  );

  // A request arriving on the grant cycle starts a fresh pending bit, not a loss.
  always_comb begin
    w_lossv       = w_idle ? (w_pass & r_pending & ~{NUM_SRC{w_fire}})
                           : (req_i & src_en_i);
    w_pending_nxt = ((w_fire ? '0 : r_pending) | w_pass) & src_en_i;
    w_loss_n      = 0;
    for (int k = 0; k < NUM_SRC; k++) w_loss_n += 32'(w_lossv[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)        r_lost <= '0;
    else if (lost_clr_i) r_lost <= '0;
    else                 r_lost <= lost_sat_add(r_lost, w_loss_n);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= c_ST_IDLE;
      r_pending <= '0;
      r_ptr     <= SRC_W'(NUM_SRC - 1);
      r_src     <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
      r_hcnt    <= '0;
      r_tcnt    <= '0;
    end else begin
      r_timeout <= 1'b0;
      r_pending <= w_pending_nxt;
      case (r_state)
        c_ST_IDLE: begin
          if (w_fire) begin
            r_ptr   <= w_grant;
            r_src   <= w_grant;
            r_mask  <= r_pending;
            r_state <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_tcnt  <= '0;
          r_state <= c_ST_WAIT_ACK;
        end
        c_ST_WAIT_ACK: begin
          if (trig_ack_i && done_i) begin
            r_hcnt  <= holdoff_i;
            r_state <= c_ST_HOLDOFF;
          end else if (trig_ack_i) begin
            r_state <= c_ST_WAIT_DONE;
          end else if (r_tcnt == c_TCNT_W'(ACK_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_hcnt    <= holdoff_i;
            r_state   <= c_ST_HOLDOFF;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        c_ST_WAIT_DONE: begin
          if (done_i) begin
            r_hcnt  <= holdoff_i;
            r_state <= c_ST_HOLDOFF;
          end
        end
        c_ST_HOLDOFF: begin
          if (r_hcnt == '0) r_state <= c_ST_IDLE;
          else              r_hcnt  <= r_hcnt - 1'b1;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign trig_o      = (r_state == c_ST_ISSUE);
  assign trig_src_o  = r_src;
  assign trig_mask_o = r_mask;
  assign timeout_o   = r_timeout;
  assign lost_cnt_o  = r_lost;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_radiant_trig_arbiter.sv
`default_nettype none
// ============================================================================
// tb_radiant_trig_arbiter
// Directed scenario bench for the trigger arbiter.
// Revision: 1.0
// ============================================================================
module tb_radiant_trig_arbiter;

  localparam int NUM_SRC = 4;
  localparam int PW      = 8;
  localparam int HW      = 16;
  localparam int SW      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_SRC-1:0]    req, src_en;
  logic [NUM_SRC*PW-1:0] prescale;
  logic [HW-1:0]         holdoff;
  logic                  busy, ack, done, lost_clr;
  logic                  trig, timeout;
  logic [SW-1:0]         src;
  logic [NUM_SRC-1:0]    mask;
  logic [15:0]           lost;
  logic [2:0]            state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  radiant_trig_arbiter #(
    .NUM_SRC(NUM_SRC), .PRESCALE_WIDTH(PW), .HOLDOFF_WIDTH(HW), .ACK_TIMEOUT(1024)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .src_en_i(src_en),
    .prescale_i(prescale), .holdoff_i(holdoff), .busy_i(busy),
    .trig_ack_i(ack), .done_i(done), .lost_clr_i(lost_clr),
    .trig_o(trig), .trig_src_o(src), .trig_mask_o(mask),
    .timeout_o(timeout), .lost_cnt_o(lost), .state_o(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a WAIT_ACK cycle; returns in the first IDLE cycle after holdoff h.
  task automatic finish_readout(input int h);
    ack = 1'b1; done = 1'b1;
    tick();
    ack = 1'b0; done = 1'b0;
    repeat (h + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if ({trig, timeout, src, mask} !== '0) begin n_err++; $display("FAIL reset_outs: got trig=%b to=%b src=%0d mask=%b want all 0", trig, timeout, src, mask); end
    n_cmp++; if (lost !== 16'd0) begin n_err++; $display("FAIL reset_lost: got %0d want 0", lost); end
    // sources 0 and 3 together: source 0 has first priority after reset
    req = 4'b1001; tick(); req = 4'b0000; tick();
    n_cmp++; if ({trig, src, mask} !== {1'b1, 2'd0, 4'b1001}) begin n_err++; $display("FAIL reset_priority: got trig=%b src=%0d mask=%b want 1/0/1001", trig, src, mask); end
    tick();
    finish_readout(0);
    tick();
    n_cmp++; if ({trig, state} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL pending_cleared: got trig=%b state=%0d want 0/0", trig, state); end
  endtask

  task automatic test_single();
    holdoff = 16'd10;
    req = 4'b0001; tick(); req = 4'b0000; tick();
    n_cmp++; if ({trig, src} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL single_trig: got trig=%b src=%0d want 1/0", trig, src); end
    tick();
    n_cmp++; if ({trig, state} !== {1'b0, 3'd2}) begin n_err++; $display("FAIL single_pulse: got trig=%b state=%0d want 0/2", trig, state); end
    ack = 1'b1; done = 1'b1; tick(); ack = 1'b0; done = 1'b0;
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL single_holdoff: got %0d want 4", state); end
    req = 4'b0001; tick(); req = 4'b0000;
    n_cmp++; if (lost !== 16'd1) begin n_err++; $display("FAIL single_lost: got %0d want 1", lost); end
    repeat (9) tick();
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL holdoff_last: got %0d want 4", state); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL holdoff_exit: got %0d want 0", state); end
  endtask

  task automatic test_lost_clear();
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
    n_cmp++; if (lost !== 16'd0) begin n_err++; $display("FAIL lost_clear: got %0d want 0", lost); end
  endtask

  task automatic test_round_robin();
    holdoff = 16'd0;
    req = 4'b0010; tick(); req = 4'b0000; tick();
    n_cmp++; if ({trig, src} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL rr_setup: got trig=%b src=%0d want 1/1", trig, src); end
    tick(); finish_readout(0);
    req = 4'b0110; tick();
    req = 4'b0110; tick();
    req = 4'b0000;
    n_cmp++; if ({trig, src, mask} !== {1'b1, 2'd2, 4'b0110}) begin n_err++; $display("FAIL rr_first: got trig=%b src=%0d mask=%b want 1/2/0110", trig, src, mask); end
    n_cmp++; if (lost !== 16'd0) begin n_err++; $display("FAIL rr_grant_cycle_lost: got %0d want 0", lost); end
    tick(); finish_readout(0);
    tick();
    n_cmp++; if ({trig, src, mask} !== {1'b1, 2'd1, 4'b0110}) begin n_err++; $display("FAIL rr_second: got trig=%b src=%0d mask=%b want 1/1/0110", trig, src, mask); end
    tick(); finish_readout(0);
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rr_idle: got %0d want 0", state); end
  endtask

  task automatic test_prescale();
    int ntrig = 0;
    prescale = 32'h0300_0000;
    for (int i = 0; i < 8; i++) begin
      req = 4'b1000; tick(); req = 4'b0000; tick();
      n_cmp++; if (trig !== ((i % 4) == 3)) begin n_err++; $display("FAIL prescale_req%0d: got trig=%b want %b", i, trig, (i % 4) == 3); end
      if (trig === 1'b1) begin
        ntrig++;
        tick(); finish_readout(0);
      end
    end
    n_cmp++; if (ntrig !== 2) begin n_err++; $display("FAIL prescale_count: got %0d want 2", ntrig); end
    n_cmp++; if (lost !== 16'd0) begin n_err++; $display("FAIL prescale_lost: got %0d want 0", lost); end
    prescale = '0;
  endtask

  task automatic test_busy();
    int seen = 0;
    busy = 1'b1;
    req = 4'b0001; tick(); seen += int'(trig);
    req = 4'b0000; tick(); seen += int'(trig);
    req = 4'b0001; tick(); seen += int'(trig);
    req = 4'b0000;
    repeat (3) begin tick(); seen += int'(trig); end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL busy_no_trig: got %0d pulses want 0", seen); end
    n_cmp++; if (lost !== 16'd1) begin n_err++; $display("FAIL busy_lost: got %0d want 1", lost); end
    busy = 1'b0; tick();
    n_cmp++; if ({trig, src, mask} !== {1'b1, 2'd0, 4'b0001}) begin n_err++; $display("FAIL busy_release: got trig=%b src=%0d mask=%b want 1/0/0001", trig, src, mask); end
    tick(); finish_readout(0);
    tick();
    n_cmp++; if ({trig, state} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL busy_single: got trig=%b state=%0d want 0/0", trig, state); end
    // disabling a source discards its pending request
    seen = 0;
    busy = 1'b1;
    req = 4'b0100; tick(); req = 4'b0000;
    src_en = 4'b1011; tick();
    src_en = 4'b1111; tick();
    busy = 1'b0;
    repeat (3) begin tick(); seen += int'(trig); end
    n_cmp++; if ({seen[3:0], state} !== {4'd0, 3'd0}) begin n_err++; $display("FAIL en_clear: got pulses=%0d state=%0d want 0/0", seen, state); end
  endtask

  task automatic test_timeout();
    int k;
    lost_clr = 1'b1; tick(); lost_clr = 1'b0;
    holdoff = 16'd3;
    req = 4'b0001; tick(); req = 4'b0000; tick();
    n_cmp++; if (trig !== 1'b1) begin n_err++; $display("FAIL to_trig: got %b want 1", trig); end
    k = 0;
    while (k < 1100) begin
      tick(); k++;
      if (timeout === 1'b1) break;
    end
    n_cmp++; if (k !== 1025) begin n_err++; $display("FAIL to_latency: got %0d cycles want 1025", k); end
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL to_holdoff: got %0d want 4", state); end
    ack = 1'b1; req = 4'b1111; tick();
    ack = 1'b0; req = 4'b0001; lost_clr = 1'b1; holdoff = 16'd50;
    n_cmp++; if ({timeout, lost} !== {1'b0, 16'd4}) begin n_err++; $display("FAIL to_pulse_drop4: got to=%b lost=%0d want 0/4", timeout, lost); end
    tick(); lost_clr = 1'b0;
    n_cmp++; if (lost !== 16'd0) begin n_err++; $display("FAIL clr_wins: got %0d want 0", lost); end
    tick(); req = 4'b0000;
    n_cmp++; if (lost !== 16'd1) begin n_err++; $display("FAIL drop_after_clr: got %0d want 1", lost); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL to_idle: got %0d want 0", state); end
    tick();
    n_cmp++; if ({trig, state} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL late_ack: got trig=%b state=%0d want 0/0", trig, state); end
    holdoff = 16'd0;
  endtask

  task automatic test_reset_mid();
    req = 4'b0010; tick(); req = 4'b0000; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++; if ({state, src, mask} !== {3'd3, 2'd1, 4'b0010}) begin n_err++; $display("FAIL mid_wait_done: got state=%0d src=%0d mask=%b want 3/1/0010", state, src, mask); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_cmp++; if ({state, trig, src, mask, timeout, lost} !== '0) begin n_err++; $display("FAIL mid_reset: got state=%0d trig=%b src=%0d mask=%b to=%b lost=%0d want all 0", state, trig, src, mask, timeout, lost); end
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if ({state, trig} !== '0) begin n_err++; $display("FAIL mid_late_done: got state=%0d trig=%b want 0/0", state, trig); end
    tick();
    n_cmp++; if ({state, trig} !== '0) begin n_err++; $display("FAIL mid_quiet: got state=%0d trig=%b want 0/0", state, trig); end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; src_en = 4'b1111; prescale = '0; holdoff = '0;
    busy = 1'b0; ack = 1'b0; done = 1'b0; lost_clr = 1'b0;
    test_reset();
    test_single();
    test_lost_clear();
    test_round_robin();
    test_prescale();
    test_busy();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached limit 1000000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
